// File: rtl/noc_local_inject_queue_if.sv
// Tile-side valid/ready and router-side void/stop signals of the local inject queue.
interface noc_local_inject_queue_if #(
   parameter int Width = 32,
   parameter int Depth = 4
);
   localparam int LW = $clog2(Depth + 1);

   logic [Width-1:0] tile_data_in;
   logic             tile_valid_in;
   logic             tile_ready_out;
   logic [Width-1:0] data_p_out;
   logic             data_void_p_out;
   logic             stop_p_in;
   logic [LW-1:0]    level_out;
   logic             proto_err_out;

   modport slave (
      input  tile_data_in, tile_valid_in, stop_p_in,
      output tile_ready_out, data_p_out, data_void_p_out, level_out, proto_err_out
   );

   modport master (
      output tile_data_in, tile_valid_in, stop_p_in,
      input  tile_ready_out, data_p_out, data_void_p_out, level_out, proto_err_out
   );
endinterface

// File: rtl/noc_local_inject_queue.sv
// Local-port inject FIFO holding packets until whole (or FIFO full); 1-cycle min latency, stop stalls in place.
// Defining NOC_INJECT_STATS_EN adds saturating pkt_count_out / stall_count_out counters.
module noc_local_inject_queue #(
   parameter int Width = 32,
   parameter int Depth = 4
) (
   input logic                     clk,
   input logic                     rst,
   noc_local_inject_queue_if.slave io_bus
`ifdef NOC_INJECT_STATS_EN
   ,
   output logic [15:0]             pkt_count_out,
   output logic [15:0]             stall_count_out
`endif
);
   localparam int AW = $clog2(Depth);
   localparam int LW = $clog2(Depth + 1);

   typedef enum logic {S_IDLE, S_SEND} state_t;

   state_t           r_state, w_state_nxt;
   logic [Width-1:0] r_mem [Depth];
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [LW-1:0]    r_level, r_tail_cnt;
   logic             r_proto_err;
   logic [Width-1:0] w_front;
   logic             w_empty, w_full, w_push, w_pop, w_void;
   logic             w_head, w_tail, w_tail_in, w_bad_front;

   assign w_empty   = (r_level == '0);
   assign w_full    = (r_level == LW'(Depth));
   assign w_front   = r_mem[r_rd_ptr];
   assign w_head    = w_front[Width-1];
   assign w_tail    = w_front[Width-2];
   assign w_tail_in = io_bus.tile_data_in[Width-2];

   // Ready looks only at full so a same-cycle pop never opens a push slot.
   assign io_bus.tile_ready_out = rst & ~w_full;
   assign w_push = io_bus.tile_valid_in & io_bus.tile_ready_out;

   // In IDLE a packet waits until its tail is buffered; a full FIFO launches anyway to avoid deadlock.
   assign w_void = (r_state == S_SEND) ? w_empty
                                       : (w_empty | ((r_tail_cnt == '0) & ~w_full));
   assign w_pop       = ~w_void & ~io_bus.stop_p_in;
   assign w_bad_front = (r_state == S_IDLE) & ~w_empty & ~w_head;

   assign io_bus.data_p_out      = w_front;
   assign io_bus.data_void_p_out = w_void;
   assign io_bus.level_out       = r_level;
   assign io_bus.proto_err_out   = r_proto_err;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_pop & w_head & ~w_tail) w_state_nxt = S_SEND;
         S_SEND:  if (w_pop & w_tail)           w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= io_bus.tile_data_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_tail_cnt  <= '0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
         case ({w_push & w_tail_in, w_pop & w_tail})
            2'b10:   r_tail_cnt <= r_tail_cnt + LW'(1);
            2'b01:   r_tail_cnt <= r_tail_cnt - LW'(1);
            default: r_tail_cnt <= r_tail_cnt;
         endcase
         if (w_bad_front) r_proto_err <= 1'b1;
      end
   end

`ifdef NOC_INJECT_STATS_EN
   logic [15:0] r_pkt_cnt, r_stall_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pkt_cnt   <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_pop & w_tail & (r_pkt_cnt != 16'hFFFF))
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
         if (~w_void & io_bus.stop_p_in & (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign pkt_count_out   = r_pkt_cnt;
   assign stall_count_out = r_stall_cnt;
`endif
endmodule

// File: tb/tb_noc_local_inject_queue.sv
// Bench for noc_local_inject_queue: per-cycle vector table plus flit scoreboard and hand-written corner sequences.
module tb_noc_local_inject_queue;
   localparam int W  = 32;
   localparam int D  = 4;
   localparam int NV = 30;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   noc_local_inject_queue_if #(.Width(W), .Depth(D)) bus ();

`ifdef NOC_INJECT_STATS_EN
   logic [15:0] pkt_count, stall_count;
`endif

   noc_local_inject_queue #(.Width(W), .Depth(D)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
`ifdef NOC_INJECT_STATS_EN
      ,
      .pkt_count_out   (pkt_count),
      .stall_count_out (stall_count)
`endif
   );

   typedef struct {
      logic        vld;
      logic [31:0] dat;
      logic        stop;
      logic        e_void;
      logic        e_rdy;
      logic [2:0]  e_lvl;
      logic [31:0] e_dat;
   } vec_t;

   vec_t        vt [NV];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_pops  = 0;
   logic [31:0] sbq [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic [31:0] d, input logic s,
                               input logic ev, input logic er, input logic [2:0] el,
                               input logic [31:0] ed);
      vec_t r;
      r.vld = v; r.dat = d; r.stop = s; r.e_void = ev; r.e_rdy = er; r.e_lvl = el; r.e_dat = ed;
      return r;
   endfunction

   // Apply inputs just after the rising edge; judge just after the falling edge.
   task automatic drive(input logic v, input logic [31:0] d, input logic s);
      @(posedge clk);
      #1;
      bus.tile_valid_in = v;
      bus.tile_data_in  = d;
      bus.stop_p_in     = s;
      @(negedge clk);
      #1;
   endtask

   // Scoreboard: accepted flits queued, every router-side transfer checked against the head.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.tile_valid_in && bus.tile_ready_out) sbq.push_back(bus.tile_data_in);
         if (!bus.data_void_p_out && !bus.stop_p_in) begin
            n_pops++;
            if (sbq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL pop_unexpected: got %08h, expected no flit", bus.data_p_out);
            end else begin
               chk("pop_order", bus.data_p_out, sbq.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] fl [20];
      int idx, pops0, cyc;

      vt[0]  = mk(1, 32'hC000_0001, 0, 1, 1, 0, 0);
      vt[1]  = mk(0, 0,             0, 0, 1, 1, 32'hC000_0001);
      vt[2]  = mk(0, 0,             0, 1, 1, 0, 0);
      vt[3]  = mk(1, 32'h8000_0010, 0, 1, 1, 0, 0);
      vt[4]  = mk(0, 0,             0, 1, 1, 1, 0);
      vt[5]  = mk(0, 0,             0, 1, 1, 1, 0);
      vt[6]  = mk(1, 32'h0000_0011, 0, 1, 1, 1, 0);
      vt[7]  = mk(0, 0,             0, 1, 1, 2, 0);
      vt[8]  = mk(0, 0,             0, 1, 1, 2, 0);
      vt[9]  = mk(1, 32'h4000_0012, 0, 1, 1, 2, 0);
      vt[10] = mk(0, 0,             0, 0, 1, 3, 32'h8000_0010);
      vt[11] = mk(0, 0,             0, 0, 1, 2, 32'h0000_0011);
      vt[12] = mk(0, 0,             0, 0, 1, 1, 32'h4000_0012);
      vt[13] = mk(0, 0,             0, 1, 1, 0, 0);
      vt[14] = mk(1, 32'h8000_0020, 0, 1, 1, 0, 0);
      vt[15] = mk(1, 32'h0000_0021, 0, 1, 1, 1, 0);
      vt[16] = mk(1, 32'h0000_0022, 0, 1, 1, 2, 0);
      vt[17] = mk(1, 32'h0000_0023, 1, 1, 1, 3, 0);
      for (int i = 18; i < 23; i++) vt[i] = mk(1, 32'h0000_0024, 1, 0, 0, 4, 32'h8000_0020);
      vt[23] = mk(0, 0,             0, 0, 0, 4, 32'h8000_0020);
      vt[24] = mk(0, 0,             0, 0, 1, 3, 32'h0000_0021);
      vt[25] = mk(0, 0,             0, 0, 1, 2, 32'h0000_0022);
      vt[26] = mk(0, 0,             0, 0, 1, 1, 32'h0000_0023);
      vt[27] = mk(1, 32'h4000_0024, 0, 1, 1, 0, 0);
      vt[28] = mk(0, 0,             0, 0, 1, 1, 32'h4000_0024);
      vt[29] = mk(0, 0,             0, 1, 1, 0, 0);

      // Reset held with a valid flit offered.
      bus.tile_valid_in = 1'b1;
      bus.tile_data_in  = 32'hDEAD_BEEF;
      bus.stop_p_in     = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_void",  bus.data_void_p_out, 1);
      chk("rst_ready", bus.tile_ready_out, 0);
      chk("rst_level", bus.level_out, 0);
      chk("rst_err",   bus.proto_err_out, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.tile_valid_in = 1'b0;
      @(negedge clk);
      #1;
      chk("rel_ready", bus.tile_ready_out, 1);
      chk("rel_void",  bus.data_void_p_out, 1);
`ifdef NOC_INJECT_STATS_EN
      chk("rst_pkt",   pkt_count, 0);
      chk("rst_stall", stall_count, 0);
`endif

      // Single flit, 3-flit packet, full-launch with stall, SEND bubble.
      for (int i = 0; i < NV; i++) begin
         drive(vt[i].vld, vt[i].dat, vt[i].stop);
         chk($sformatf("v%0d_void", i),  bus.data_void_p_out, vt[i].e_void);
         chk($sformatf("v%0d_ready", i), bus.tile_ready_out, vt[i].e_rdy);
         chk($sformatf("v%0d_level", i), bus.level_out, vt[i].e_lvl);
         if (!vt[i].e_void) chk($sformatf("v%0d_data", i), bus.data_p_out, vt[i].e_dat);
      end
      chk("tbl_err", bus.proto_err_out, 0);
`ifdef NOC_INJECT_STATS_EN
      chk("tbl_stall", stall_count, 5);
      chk("tbl_pkt",   pkt_count, 3);
`endif

      // Fill to full under stop, then stream 20 single-flit packets through the wrap.
      for (int i = 0; i < 20; i++) fl[i] = 32'hC000_0100 + i;
      idx   = 0;
      pops0 = n_pops;
      cyc   = 0;
      while (idx < 4 && cyc < 20) begin
         drive(1, fl[idx], 1);
         if (bus.tile_valid_in && bus.tile_ready_out) idx++;
         cyc++;
      end
      drive(1, fl[idx], 0);
      chk("full_ready", bus.tile_ready_out, 0);
      chk("full_level", bus.level_out, 4);
      drive(1, fl[idx], 0);
      chk("resume_ready", bus.tile_ready_out, 1);
      chk("resume_level", bus.level_out, 3);
      if (bus.tile_valid_in && bus.tile_ready_out) idx++;
      cyc = 0;
      while ((idx < 20 || (n_pops - pops0) < 20) && cyc < 200) begin
         drive(idx < 20, (idx < 20) ? fl[idx] : 32'h0, 0);
         if (bus.tile_valid_in && bus.tile_ready_out) idx++;
         cyc++;
      end
      chk("stream_pops", n_pops - pops0, 20);
      drive(0, 0, 0);
      chk("stream_level", bus.level_out, 0);
      chk("stream_sbq",   sbq.size(), 0);
`ifdef NOC_INJECT_STATS_EN
      chk("stream_pkt", pkt_count, 23);
`endif

      // Headless flits in IDLE: forwarded, error flag sticks.
      drive(1, 32'h0000_0007, 0);
      drive(1, 32'h4000_0008, 0);
      drive(0, 0, 0);
      chk("nohead_void", bus.data_void_p_out, 0);
      drive(0, 0, 0);
      drive(0, 0, 0);
      chk("nohead_err",   bus.proto_err_out, 1);
      chk("nohead_level", bus.level_out, 0);
      drive(1, 32'h8000_0030, 0);
      drive(1, 32'h0000_0031, 0);
      drive(0, 0, 0);
      chk("sticky_err",  bus.proto_err_out, 1);
      chk("partial_lvl", bus.level_out, 2);

      // Asynchronous reset mid-packet takes effect between edges.
      #2;
      rst = 1'b0;
      #1;
      chk("arst_void",  bus.data_void_p_out, 1);
      chk("arst_level", bus.level_out, 0);
      chk("arst_err",   bus.proto_err_out, 0);
      chk("arst_ready", bus.tile_ready_out, 0);
      sbq.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("rel2_ready", bus.tile_ready_out, 1);
      chk("rel2_void",  bus.data_void_p_out, 1);
`ifdef NOC_INJECT_STATS_EN
      chk("arst_pkt", pkt_count, 0);
`endif
      drive(1, 32'hC000_0040, 0);
      drive(0, 0, 0);
      chk("post_void", bus.data_void_p_out, 0);
      chk("post_data", bus.data_p_out, 32'hC000_0040);
      drive(0, 0, 0);
      chk("post_level", bus.level_out, 0);
      chk("post_sbq",   sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
